// File: rtl/mac_rx_stats_gen.sv
// Passive MAC rx statistics: timestamp, word, packet and error counters with periodic coherent snapshots.
// Latency: an event is published on the first snapshot edge after it, at most UPDATE_PERIOD cycles later.
// Backpressure: none; monitor only, a beat counts only when mon_tvalid and mon_tready are both high.
module mac_rx_stats_gen #(
  parameter int KEEP_WIDTH    = 8,
  parameter int MAX_PKT_WORDS = 190,
  parameter int UPDATE_PERIOD = 16
) (
  input  logic                  rx_clk,
  input  logic                  rst_n,
  input  logic                  mon_tvalid,
  input  logic                  mon_tready,
  input  logic                  mon_tlast,
  input  logic [KEEP_WIDTH-1:0] mon_tkeep,
  input  logic                  mon_tuser,
  input  logic                  stat_clr,
  output logic [63:0]           stat_mac_rx_ts,
  output logic [31:0]           stat_mac_rx_word_cnt,
  output logic [31:0]           stat_mac_rx_pkt_cnt,
  output logic [31:0]           stat_mac_rx_err_cnt,
  output logic                  stat_update
);

  localparam int              PW          = $clog2(UPDATE_PERIOD);
  localparam logic [PW-1:0]   PERIOD_LAST = PW'(UPDATE_PERIOD - 1);
  localparam logic [15:0]     MAX_LEN     = 16'(MAX_PKT_WORDS);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          beat;
  logic [15:0]   len;
  logic [15:0]   len_inc;
  logic          err_flag;
  logic          acc_err;
  logic          beat_err;
  logic          pkt_end;
  logic          pkt_bad;

  logic [63:0]   ts_cnt;
  logic [63:0]   ts_i;
  logic [31:0]   word_i;
  logic [31:0]   pkt_i;
  logic [31:0]   err_i;
  logic [PW-1:0] period_cnt;
  logic          publish;

  assign beat    = mon_tvalid & mon_tready;
  assign publish = (period_cnt == PERIOD_LAST);

  // Packet FSM state register; reset drops any partial packet.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a non-last beat opens or continues a packet, a last beat closes it.
  always_comb begin
    state_nxt = state;
    if (beat) begin
      state_nxt = mon_tlast ? IDLE : IN_PKT;
    end
  end

  // Per-beat checks and packet-end evaluation, including the current beat's checks.
  always_comb begin
    len_inc = 16'd1;
    acc_err = 1'b0;
    if (state == IN_PKT) begin
      len_inc = (len == 16'hFFFF) ? len : len + 16'd1;
      acc_err = err_flag;
    end
    beat_err = mon_tuser
             | (!mon_tlast && (mon_tkeep != '1))
             | (mon_tlast && (mon_tkeep == '0))
             | (len_inc > MAX_LEN);
    pkt_end  = beat & mon_tlast;
    pkt_bad  = acc_err | beat_err;
  end

  // Length and sticky error of the packet in flight; stat_clr leaves these alone.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      len      <= 16'd0;
      err_flag <= 1'b0;
    end else if (beat && !mon_tlast) begin
      len      <= len_inc;
      err_flag <= pkt_bad;
    end
  end

  // Free-running timestamp, immune to stat_clr.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= 64'd0;
    end else begin
      ts_cnt <= ts_cnt + 64'd1;
    end
  end

  // Internal counters; a clear on the same edge discards that edge's increment.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_i <= 32'd0;
      pkt_i  <= 32'd0;
      err_i  <= 32'd0;
      ts_i   <= 64'd0;
    end else if (stat_clr) begin
      word_i <= 32'd0;
      pkt_i  <= 32'd0;
      err_i  <= 32'd0;
      ts_i   <= 64'd0;
    end else begin
      if (beat) begin
        word_i <= word_i + 32'd1;
      end
      if (pkt_end) begin
        if (pkt_bad) begin
          err_i <= err_i + 32'd1;
        end else begin
          pkt_i <= pkt_i + 32'd1;
          ts_i  <= ts_cnt;
        end
      end
    end
  end

  // Snapshot period counter; a clear forces a publish on the very next edge.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else if (stat_clr) begin
      period_cnt <= PERIOD_LAST;
    end else if (publish) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // Published snapshot: loads only on publish edges so the CDC sees stable values.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_mac_rx_ts       <= 64'd0;
      stat_mac_rx_word_cnt <= 32'd0;
      stat_mac_rx_pkt_cnt  <= 32'd0;
      stat_mac_rx_err_cnt  <= 32'd0;
      stat_update          <= 1'b0;
    end else begin
      stat_update <= publish;
      if (publish) begin
        stat_mac_rx_ts       <= ts_i;
        stat_mac_rx_word_cnt <= word_i;
        stat_mac_rx_pkt_cnt  <= pkt_i;
        stat_mac_rx_err_cnt  <= err_i;
      end
    end
  end

endmodule
